// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - two-requester round-robin write arbiter with credit tracking for an 8-entry FIFO
// Optional statistics counters are enabled by defining FIFO_WR_ARB_STAT_EN.
module fifo_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] din0,
  input  logic              req1,
  input  logic [DATA_W-1:0] din1,
  input  logic              fifo_rd_en,
  output logic              gnt0,
  output logic              gnt1,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic [CNT_W-1:0]  credit_cnt,
  output logic              arb_full,
  output logic              arb_empty
`ifdef FIFO_WR_ARB_STAT_EN
  ,
  output logic [7:0]        gnt_cnt0,
  output logic [7:0]        gnt_cnt1,
  output logic [7:0]        stall_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GRANT = 2'b01;
  localparam logic [1:0] STALL = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             last;        // 1 when requester 1 won the most recent grant
  logic             ereq0;
  logic             ereq1;
  logic             rd_ok;
  logic             space;
  logic             issue;
  logic             win1;
  logic [CNT_W-1:0] credit_next;

  // Arbitration decision for the coming edge: self-exclusion, credit space and round-robin winner
  always_comb begin
    ereq0 = req0 & ~gnt0;
    ereq1 = req1 & ~gnt1;
    // A read on an empty FIFO is an underflow on the FIFO side and returns no credit
    rd_ok = fifo_rd_en & (credit_cnt != '0);
    // A slot freed by a read at this edge can take a write landing in the next cycle
    space = (credit_cnt < CNT_MAX) | rd_ok;
    issue = space & (ereq0 | ereq1);
    // With both requesting, the one that did not win last time goes
    win1  = ereq1 & (~ereq0 | ~last);
  end

  // Credit count follows issued writes minus accepted reads
  always_comb begin
    credit_next = credit_cnt;
    case ({issue, rd_ok})
      2'b10:   credit_next = credit_cnt + 1'b1;
      2'b01:   credit_next = credit_cnt - 1'b1;
      default: credit_next = credit_cnt;
    endcase
  end

  // Next-state: any pending request is either granted or stalled for lack of credit
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE, GRANT, STALL: begin
        if (ereq0 | ereq1) begin
          state_next = space ? GRANT : STALL;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered grant, write strobe, write data, round-robin pointer and credit count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      last       <= 1'b1;
      credit_cnt <= '0;
      state      <= IDLE;
    end else begin
      state      <= state_next;
      credit_cnt <= credit_next;
      fifo_wr_en <= issue;
      gnt0       <= issue & ~win1;
      gnt1       <= issue & win1;
      if (issue) begin
        fifo_din <= win1 ? din1 : din0;
        last     <= win1;
      end
    end
  end

  assign arb_full  = (credit_cnt == CNT_MAX);
  assign arb_empty = (credit_cnt == '0);

`ifdef FIFO_WR_ARB_STAT_EN
  // Saturating per-requester grant counters and stall-cycle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_cnt0  <= '0;
      gnt_cnt1  <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue && !win1 && gnt_cnt0 != 8'hFF) begin
        gnt_cnt0 <= gnt_cnt0 + 8'd1;
      end
      if (issue && win1 && gnt_cnt1 != 8'hFF) begin
        gnt_cnt1 <= gnt_cnt1 + 8'd1;
      end
      if (state == STALL && stall_cnt != 8'hFF) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter with a queue-based reference model
module tb_fifo_wr_arbiter;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req0;
  logic [DATA_W-1:0] din0;
  logic              req1;
  logic [DATA_W-1:0] din1;
  logic              fifo_rd_en;
  logic              gnt0;
  logic              gnt1;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_din;
  logic [CNT_W-1:0]  credit_cnt;
  logic              arb_full;
  logic              arb_empty;
`ifdef FIFO_WR_ARB_STAT_EN
  logic [7:0]        gnt_cnt0;
  logic [7:0]        gnt_cnt1;
  logic [7:0]        stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as a queue, last winner as a requester number
  logic [DATA_W-1:0] mq[$];
  int                m_last;
  logic              m_gnt0;
  logic              m_gnt1;
  logic              m_wr;
  logic [DATA_W-1:0] m_din;
  logic              m_in_stall;
  int                m_gc0;
  int                m_gc1;
  int                m_sc;

  fifo_wr_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0       (req0),
    .din0       (din0),
    .req1       (req1),
    .din1       (din1),
    .fifo_rd_en (fifo_rd_en),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .credit_cnt (credit_cnt),
    .arb_full   (arb_full),
    .arb_empty  (arb_empty)
`ifdef FIFO_WR_ARB_STAT_EN
    ,
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_last     = 1;
    m_gnt0     = 1'b0;
    m_gnt1     = 1'b0;
    m_wr       = 1'b0;
    m_din      = '0;
    m_in_stall = 1'b0;
    m_gc0      = 0;
    m_gc1      = 0;
    m_sc       = 0;
  endtask

  // Drive inputs, advance one clock edge in both DUT and model, return at the falling edge
  task automatic step(input logic r0, input logic [DATA_W-1:0] d0,
                      input logic r1, input logic [DATA_W-1:0] d1, input logic rd);
    bit e0, e1, rdok, sp;
    int w;
    req0 = r0; din0 = d0; req1 = r1; din1 = d1; fifo_rd_en = rd;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      e0   = r0 && !m_gnt0;
      e1   = r1 && !m_gnt1;
      rdok = rd && (mq.size() != 0);
      sp   = (mq.size() < DEPTH) || rdok;
      if (m_in_stall && m_sc < 255) m_sc++;
      m_in_stall = (e0 || e1) && !sp;
      if (rdok) void'(mq.pop_front());
      m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_wr = 1'b0;
      if (sp && (e0 || e1)) begin
        if (e0 && e1) w = (m_last == 0) ? 1 : 0;
        else          w = e1 ? 1 : 0;
        m_last = w;
        m_wr   = 1'b1;
        m_din  = (w == 1) ? d1 : d0;
        mq.push_back(m_din);
        if (w == 1) begin m_gnt1 = 1'b1; if (m_gc1 < 255) m_gc1++; end
        else        begin m_gnt0 = 1'b1; if (m_gc0 < 255) m_gc0++; end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0; fifo_rd_en = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || fifo_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: gnt0=%b gnt1=%b wr_en=%b required 0 0 0", gnt0, gnt1, fifo_wr_en);
    end
    n_checks++;
    if (fifo_din !== 32'h0 || credit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_values: fifo_din=%h credit_cnt=%0d required 0 0", fifo_din, credit_cnt);
    end
    n_checks++;
    if (arb_empty !== 1'b1 || arb_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: empty=%b full=%b required 1 0", arb_empty, arb_full);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 32'hA5A5_0001, 1'b0, '0, 1'b0);
    n_checks++;
    if (gnt0 !== 1'b1 || fifo_wr_en !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: gnt0=%b gnt1=%b wr_en=%b required 1 0 1", gnt0, gnt1, fifo_wr_en);
    end
    n_checks++;
    if (fifo_din !== 32'hA5A5_0001 || credit_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL single_data: fifo_din=%h credit=%0d required a5a50001 1", fifo_din, credit_cnt);
    end
    step(1'b1, 32'hA5A5_0001, 1'b0, '0, 1'b0);
    n_checks++;
    if (gnt0 !== 1'b0 || fifo_wr_en !== 1'b0 || credit_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL self_exclusion: gnt0=%b wr_en=%b credit=%0d required 0 0 1", gnt0, fifo_wr_en, credit_cnt);
    end
  endtask

  task automatic test_alternate();
    logic [DATA_W-1:0] exp_d;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h10, 1'b1, 32'h20, 1'b1);
      exp_d = (i % 2 == 0) ? 32'h10 : 32'h20;
      n_checks++;
      if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1) || fifo_wr_en !== 1'b1 || fifo_din !== exp_d) begin
        n_fail++;
        $display("FAIL alternate[%0d]: gnt0=%b gnt1=%b wr_en=%b din=%h required din=%h", i, gnt0, gnt1, fifo_wr_en, fifo_din, exp_d);
      end
    end
  endtask

  task automatic test_full_stall();
    int writes = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
      if (fifo_wr_en === 1'b1) writes++;
    end
    n_checks++;
    if (writes != 8) begin
      n_fail++;
      $display("FAIL full_write_count: writes=%0d required 8", writes);
    end
    n_checks++;
    if (credit_cnt !== 4'd8 || arb_full !== 1'b1 || dut.state !== 2'b10) begin
      n_fail++;
      $display("FAIL full_state: credit=%0d full=%b state=%b required 8 1 10", credit_cnt, arb_full, dut.state);
    end
    step(1'b1, 32'h100, 1'b1, 32'h200, 1'b1);
    n_checks++;
    if (fifo_wr_en !== 1'b1 || (gnt0 ^ gnt1) !== 1'b1 || credit_cnt !== 4'd8) begin
      n_fail++;
      $display("FAIL full_read_regrant: wr_en=%b gnt0=%b gnt1=%b credit=%0d required one grant, credit 8", fifo_wr_en, gnt0, gnt1, credit_cnt);
    end
    step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    n_checks++;
    if (fifo_wr_en !== 1'b0 || credit_cnt !== 4'd8) begin
      n_fail++;
      $display("FAIL full_no_extra: wr_en=%b credit=%0d required 0 8", fifo_wr_en, credit_cnt);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h1, 1'b1, 32'h2, 1'b0);
    n_checks++;
    if (credit_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL credit_three: credit=%0d required 3", credit_cnt);
    end
    step(1'b1, 32'h1, 1'b1, 32'h2, 1'b1);
    n_checks++;
    if (credit_cnt !== 4'd3 || fifo_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL write_and_read: credit=%0d wr_en=%b required 3 1", credit_cnt, fifo_wr_en);
    end
    do_reset();
    step(1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    n_checks++;
    if (credit_cnt !== 4'd0 || arb_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL read_when_empty: credit=%0d empty=%b required 0 1", credit_cnt, arb_empty);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 32'h55, 1'b1, 32'h66, 1'b0);
    step(1'b1, 32'h55, 1'b1, 32'h66, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || fifo_wr_en !== 1'b0 || credit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: gnt0=%b gnt1=%b wr_en=%b credit=%0d required 0 0 0 0", gnt0, gnt1, fifo_wr_en, credit_cnt);
    end
    model_reset();
    @(negedge clk);
    step(1'b1, 32'h55, 1'b1, 32'h66, 1'b0);
    reset_n = 1'b1;
    step(1'b1, 32'h55, 1'b1, 32'h66, 1'b0);
    n_checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || fifo_din !== 32'h55) begin
      n_fail++;
      $display("FAIL regrant_after_reset: gnt0=%b gnt1=%b din=%h required 1 0 00000055", gnt0, gnt1, fifo_din);
    end
  endtask

  task automatic test_random();
    logic              r0, r1, rd;
    logic [DATA_W-1:0] d0, d1;
    do_reset();
    r0 = 1'b0; r1 = 1'b0; d0 = '0; d1 = '0;
    for (int i = 0; i < 500; i++) begin
      // Producers hold a request until granted, then may start a new one
      if (!r0 || m_gnt0) begin r0 = ($urandom_range(0, 2) != 0); d0 = $urandom; end
      if (!r1 || m_gnt1) begin r1 = ($urandom_range(0, 2) != 0); d1 = $urandom; end
      rd = ($urandom_range(0, 2) == 0);
      step(r0, d0, r1, d1, rd);
      n_checks++;
      if (gnt0 !== m_gnt0 || gnt1 !== m_gnt1 || fifo_wr_en !== m_wr || fifo_din !== m_din) begin
        n_fail++;
        $display("FAIL random_grant[%0d]: gnt=%b%b wr=%b din=%h required gnt=%b%b wr=%b din=%h", i, gnt0, gnt1, fifo_wr_en, fifo_din, m_gnt0, m_gnt1, m_wr, m_din);
      end
      n_checks++;
      if (credit_cnt !== CNT_W'(mq.size()) || arb_full !== (mq.size() == DEPTH) || arb_empty !== (mq.size() == 0)) begin
        n_fail++;
        $display("FAIL random_credit[%0d]: credit=%0d full=%b empty=%b required %0d", i, credit_cnt, arb_full, arb_empty, mq.size());
      end
    end
  endtask

`ifdef FIFO_WR_ARB_STAT_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 600; i++) step(1'b1, 32'h7, 1'b0, '0, 1'b1);
    n_checks++;
    if (gnt_cnt0 !== 8'd255 || gnt_cnt1 !== 8'd0 || m_gc0 != 255) begin
      n_fail++;
      $display("FAIL stat_gnt_sat: gnt_cnt0=%0d gnt_cnt1=%0d required 255 0", gnt_cnt0, gnt_cnt1);
    end
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, 32'h1, 1'b1, 32'h2, 1'b0);
    n_checks++;
    if (stall_cnt !== 8'd5 || stall_cnt !== 8'(m_sc)) begin
      n_fail++;
      $display("FAIL stat_stall: stall_cnt=%0d required 5 (model %0d)", stall_cnt, m_sc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_full_stall();
    test_simultaneous();
    test_async_reset();
    test_random();
`ifdef FIFO_WR_ARB_STAT_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
